wb_timer: RTL and testbench

- Wishbone slave timer occupying interconnect slave 4 (address prefix 0xF002) beside bram0 and uart0.
- Provides two independent 32-bit up-counters (timer0, timer1), each with its own compare register, auto-reload and match interrupt.
- The CPU reads and writes it through the interconnect.
- The combined interrupt output feeds the CPU interrupt vector.

---
 rtl/wb_timer.sv | 136 +++++++++++++
 tb/tb_wb_timer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// Wishbone slave with two 32-bit compare/auto-reload up-counters sharing one
// prescaler; registered single-cycle ack, registered read data, level interrupt.
module wb_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             intr_q, intr_d;
  logic [15:0]      presc_q, presc_d;
  logic [1:0]       en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d;
  logic [1:0][31:0] cmp_q, cmp_d, cnt_q, cnt_d;

  logic        req, wr_en, tick;
  logic [1:0]  hit;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic        unused_adr;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    return res;
  endfunction

  // A request is only accepted while no ack is outstanding, so acks are one-cycle pulses.
  assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en      = req & wb_we_i;
  assign reg_sel    = wb_adr_i[4:2];
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign tick       = (presc_q == PRESCALE_LAST);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign hit[gi] = tick & en_q[gi] & (cnt_q[gi] == cmp_q[gi]);
    end
  endgenerate

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    match_d = match_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    presc_d = 16'd0;
    if (|en_q) presc_d = tick ? 16'd0 : presc_q + 16'd1;

    for (int n = 0; n < 2; n++) begin
      if (tick && en_q[n]) begin
        if (hit[n]) begin
          if (ar_q[n]) cnt_d[n] = 32'd0;
          else         en_d[n]  = 1'b0;
        end else begin
          cnt_d[n] = cnt_q[n] + 32'd1;
        end
      end
      // Bus writes are applied after the count decision so the bus value wins.
      if (wr_en && reg_sel == 3'(3*n) && wb_sel_i[0]) begin
        en_d[n]    = wb_dat_i[0];
        ar_d[n]    = wb_dat_i[1];
        ie_d[n]    = wb_dat_i[2];
        match_d[n] = 1'b0;
        if (wb_dat_i[3]) cnt_d[n] = 32'd0;
      end
      if (wr_en && reg_sel == 3'(3*n + 1)) cmp_d[n] = byte_merge(cmp_q[n], wb_dat_i, wb_sel_i);
      if (wr_en && reg_sel == 3'(3*n + 2)) cnt_d[n] = byte_merge(cnt_q[n], wb_dat_i, wb_sel_i);
      if (hit[n]) match_d[n] = 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      3'd0:    rdata = {28'd0, match_q[0], ie_q[0], ar_q[0], en_q[0]};
      3'd1:    rdata = cmp_q[0];
      3'd2:    rdata = cnt_q[0];
      3'd3:    rdata = {28'd0, match_q[1], ie_q[1], ar_q[1], en_q[1]};
      3'd4:    rdata = cmp_q[1];
      3'd5:    rdata = cnt_q[1];
      default: rdata = 32'd0;
    endcase
    ack_d  = req;
    dat_d  = (req && !wb_we_i) ? rdata : 32'd0;
    intr_d = |(match_q & ie_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      intr_q  <= 1'b0;
      presc_q <= 16'd0;
      en_q    <= 2'd0;
      ar_q    <= 2'd0;
      ie_q    <= 2'd0;
      match_q <= 2'd0;
      cmp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      intr_q  <= intr_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      match_q <= match_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: two instances (PRESCALE 1 and 4) on a shared bus, checked
// against counter values derived arithmetically from elapsed ticks.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        stb, we, cyc1, cyc4;
  logic [31:0] dat1, dat4;
  logic        ack1, ack4, intr1, intr4;

  int tests = 0;
  int fails = 0;
  int edge_count = 0;
  int last_edge = 0;
  int last_lat = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  wb_timer #(.PRESCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat1),
    .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc1), .wb_we_i(we), .wb_ack_o(ack1),
    .intr(intr1));

  wb_timer #(.PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat4),
    .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc4), .wb_we_i(we), .wb_ack_o(ack4),
    .intr(intr4));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model: counter state from elapsed ticks ----------------
  function automatic longint ticks_of(input int k, input int p);
    return (k < 0) ? 0 : longint'(k / p);
  endfunction

  function automatic logic [31:0] os_cnt(input int k, input int p, input logic [31:0] start,
                                         input logic [31:0] cmp);
    longint t, d;
    t = ticks_of(k, p);
    d = {32'd0, 32'(cmp - start)};
    if (t <= d) return start + 32'(t);
    return cmp;
  endfunction

  function automatic logic os_match(input int k, input int p, input logic [31:0] start,
                                    input logic [31:0] cmp);
    longint t, d;
    t = ticks_of(k, p);
    d = {32'd0, 32'(cmp - start)};
    return t > d;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] cur, input logic [31:0] nv,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nv[8*b +: 8];
    return r;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int n);
    while (edge_count < n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input int which, input logic w, input int r, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
    int n;
    logic got;
    adr  = {27'($urandom), 3'(r), 2'($urandom)};
    wdat = d;
    sel  = s;
    we   = w;
    stb  = 1'b1;
    if (which == 1) cyc1 = 1'b1; else cyc4 = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      got = (which == 1) ? ack1 : ack4;
    end
    q = (which == 1) ? dat1 : dat4;
    last_edge = edge_count;
    last_lat  = n;
    stb = 1'b0; we = 1'b0; cyc1 = 1'b0; cyc4 = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bus_timeout dut%0d reg%0d: got no ack, required ack within 8 cycles", which, r);
    end
  endtask

  task automatic wr(input int which, input int r, input logic [31:0] d);
    logic [31:0] q;
    bus(which, 1'b1, r, d, 4'hF, q);
  endtask

  task automatic rd(input int which, input int r, output logic [31:0] q);
    bus(which, 0, r, 32'd0, 4'hF, q);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] q;
    logic [31:0] d;
    rst_n = 1'b0;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(1);
    wr(1, 1, 32'd2);
    wr(1, 0, 32'h5);
    tick_n(6);
    tests++;
    if (intr1 !== 1'b1) begin fails++; $display("FAIL pre_reset_intr: got %b required 1", intr1); end
    // Start a write, then pull reset while it is outstanding.
    adr = 32'h4; wdat = 32'hDEAD_BEEF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ack1, intr1, dat1} !== 34'd0) begin
      fails++; $display("FAIL async_reset: got ack=%b intr=%b dat=%h required all 0", ack1, intr1, dat1);
    end
    stb = 1'b0; cyc1 = 1'b0; we = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(1);
    for (int which = 1; which <= 4; which += 3) begin
      for (int r = 0; r < 8; r++) begin
        rd(which, r, q);
        tests++;
        if (q !== 32'd0 || last_lat != 1 || (which == 1 ? intr1 : intr4) !== 1'b0) begin
          fails++;
          $display("FAIL reset_read dut%0d reg%0d: got %h lat %0d, required 0 lat 1 intr 0", which, r, q, last_lat);
        end
        tick_n(1);
        tests++;
        if ((which == 1 ? {ack1, dat1} : {ack4, dat4}) !== 33'd0) begin
          fails++; $display("FAIL ack_pulse dut%0d reg%0d: ack/dat still active, required 0", which, r);
        end
      end
    end
    for (int r = 6; r < 8; r++) begin
      d = $urandom;
      wr(1, r, d);
      rd(1, r, q);
      tests++;
      if (q !== 32'd0) begin fails++; $display("FAIL unused_reg%0d: got %h required 0", r, q); end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] q;
    int e, k, w;
    wr(1, 1, 32'd5);
    wr(1, 0, 32'h5);
    e = last_edge;
    for (int kk = 1; kk <= 5; kk += 2) begin
      wait_until(e + kk);
      rd(1, 2, q);
      k = last_edge - 1 - e;
      tests++;
      if (q !== os_cnt(k, 1, 32'd0, 32'd5)) begin
        fails++; $display("FAIL oneshot_cnt k=%0d: got %h required %h", k, q, os_cnt(k, 1, 32'd0, 32'd5));
      end
    end
    wait_until(e + 6);
    tests++;
    if (intr1 !== 1'b0) begin fails++; $display("FAIL oneshot_intr_early: got %b required 0", intr1); end
    tick_n(1);
    tests++;
    if (intr1 !== 1'b1) begin fails++; $display("FAIL oneshot_intr_rise: got %b required 1", intr1); end
    for (int i = 0; i < 6; i++) begin
      tick_n($urandom_range(0, 3));
      rd(1, (i % 2 == 0) ? 0 : 2, q);
      k = last_edge - 1 - e;
      tests++;
      if (i % 2 == 0) begin
        if (q !== (os_match(k, 1, 32'd0, 32'd5) ? 32'hC : 32'h5)) begin
          fails++; $display("FAIL oneshot_tcr k=%0d: got %h required C", k, q);
        end
      end else if (q !== os_cnt(k, 1, 32'd0, 32'd5)) begin
        fails++; $display("FAIL oneshot_hold k=%0d: got %h required 5", k, q);
      end
    end
    wr(1, 0, 32'h4);
    w = last_edge;
    tests++;
    if (intr1 !== 1'b1) begin fails++; $display("FAIL intr_clear_same: got %b required 1", intr1); end
    wait_until(w + 1);
    tests++;
    if (intr1 !== 1'b0) begin fails++; $display("FAIL intr_clear_next: got %b required 0", intr1); end
    rd(1, 0, q);
    tests++;
    if (q !== 32'h4) begin fails++; $display("FAIL tcr_after_clear: got %h required 4", q); end
  endtask

  task automatic test_autoreload;
    logic [31:0] q, exp;
    int e, k;
    wr(4, 4, 32'd2);
    wr(4, 3, 32'h3);
    e = last_edge;
    wait_until(e + 11);
    rd(4, 3, q);
    tests++;
    if (q !== 32'h3) begin fails++; $display("FAIL ar_tcr_before_match: got %h required 3", q); end
    wait_until(e + 13);
    rd(4, 3, q);
    tests++;
    if (q !== 32'hB) begin fails++; $display("FAIL ar_tcr_after_match: got %h required B", q); end
    for (int i = 0; i < 10; i++) begin
      tick_n($urandom_range(0, 5));
      rd(4, 5, q);
      k = last_edge - 1 - e;
      exp = 32'(ticks_of(k, 4) % 3);
      tests++;
      if (q !== exp || intr4 !== 1'b0) begin
        fails++; $display("FAIL ar_cnt k=%0d: got %h intr %b required %h intr 0", k, q, intr4, exp);
      end
    end
    wr(4, 3, 32'h0);
  endtask

  task automatic test_byte_lanes;
    logic [31:0] q, base, nv;
    logic [3:0]  s;
    logic [31:0] q2;
    wr(1, 1, 32'h1122_3344);
    bus(1, 1'b1, 1, 32'hAABB_CCDD, 4'b0101, q2);
    rd(1, 1, q);
    tests++;
    if (q !== 32'h11BB_33DD) begin fails++; $display("FAIL byte_lane_fixed: got %h required 11BB33DD", q); end
    for (int i = 0; i < 4; i++) begin
      base = $urandom; nv = $urandom; s = 4'($urandom);
      wr(1, 4, base);
      bus(1, 1'b1, 4, nv, s, q2);
      rd(1, 4, q);
      tests++;
      if (q !== lane_merge(base, nv, s)) begin
        fails++; $display("FAIL byte_lane_rand sel=%b: got %h required %h", s, q, lane_merge(base, nv, s));
      end
    end
  endtask

  task automatic test_collisions;
    logic [31:0] q, exp;
    int w, c, e;
    wr(1, 1, 32'hFFFF_0000);
    wr(1, 0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick_n($urandom_range(1, 6));
      wr(1, 2, 32'h100);
      w = last_edge;
      if (i > 0) tick_n($urandom_range(0, 3));
      rd(1, 2, q);
      exp = 32'h100 + 32'(last_edge - 1 - w);
      tests++;
      if (q !== exp) begin fails++; $display("FAIL cnt_write_on_tick: got %h required %h", q, exp); end
      wr(1, 0, 32'h9);
      w = last_edge;
      rd(1, 2, q);
      exp = 32'(last_edge - 1 - w);
      tests++;
      if (q !== exp) begin fails++; $display("FAIL tcr_zero_cnt: got %h required %h", q, exp); end
    end
    wr(1, 0, 32'h0);
    wr(1, 2, 32'h0);
    c = $urandom_range(8, 20);
    wr(1, 1, 32'(c));
    wr(1, 0, 32'h3);
    e = last_edge;
    wait_until(e + c);
    wr(1, 0, 32'h3);
    rd(1, 0, q);
    tests++;
    if (q !== 32'hB) begin fails++; $display("FAIL match_vs_tcr_write c=%0d: got %h required B", c, q); end
    wait_until(e + c + 4);
    wr(1, 0, 32'h3);
    rd(1, 0, q);
    tests++;
    if (q !== 32'h3) begin fails++; $display("FAIL tcr_write_clears_match: got %h required 3", q); end
    wr(1, 0, 32'h0);
  endtask

  task automatic test_wrap;
    logic [31:0] q, exp;
    int e, k;
    for (int ph = 0; ph < 2; ph++) begin
      wr(1, 0, 32'h0);
      wr(1, 2, 32'hFFFF_FFFE);
      wr(1, 1, 32'h1);
      wr(1, 0, 32'h1);
      e = last_edge;
      for (int kk = ph + 1; kk <= ph + 3; kk += 2) begin
        wait_until(e + kk);
        rd(1, 2, q);
        k = last_edge - 1 - e;
        exp = os_cnt(k, 1, 32'hFFFF_FFFE, 32'h1);
        tests++;
        if (q !== exp) begin fails++; $display("FAIL wrap_cnt k=%0d: got %h required %h", k, q, exp); end
      end
      wait_until(e + ph + 5);
      rd(1, 0, q);
      tests++;
      if (q !== 32'h8) begin fails++; $display("FAIL wrap_match: got %h required 8", q); end
      rd(1, 2, q);
      tests++;
      if (q !== 32'h1) begin fails++; $display("FAIL wrap_hold: got %h required 1", q); end
    end
  endtask

  task automatic test_abort;
    logic [31:0] q;
    logic        saw_ack;
    rd(1, 1, q);
    tests++;
    if (q !== 32'h1) begin fails++; $display("FAIL abort_before: got %h required 1", q); end
    tick_n(1);
    adr = 32'h4; wdat = $urandom | 32'h100; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc1 = 1'b1;
    #3 stb = 1'b0;
    saw_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_ack = saw_ack | ack1;
      cyc1 = 1'b0; we = 1'b0;
    end
    tests++;
    if (saw_ack !== 1'b0) begin fails++; $display("FAIL abort_ack: got ack 1 required none"); end
    rd(1, 1, q);
    tests++;
    if (q !== 32'h1) begin fails++; $display("FAIL abort_write: got %h required 1", q); end
  endtask

  initial begin
    rst_n = 1'b0;
    adr = 32'd0; wdat = 32'd0; sel = 4'd0; stb = 1'b0; we = 1'b0; cyc1 = 1'b0; cyc4 = 1'b0;
    test_reset;
    test_oneshot;
    test_autoreload;
    test_byte_lanes;
    test_collisions;
    test_wrap;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
